rr_arbiter_8: RTL
=================

# rr_arbiter_8

Round-robin arbiter sharing one 8-way resource between eight requesters. It takes a level request vector and produces a registered one-hot grant plus a 3-bit grant index, so the index can drive a 3-to-8 select decoder directly. A hold timer forces rotation when a requester keeps its request high while others are waiting. The block sits between the requesting agents and the decoded select / enable fabric.

## Interface
- `N`, default 8: number of requesters. Fixed at 8 for this block.
- `IDXW`, default 3: width of the grant index.
- `MAX_HOLD`, default 16: maximum consecutive cycles one grant is held while another request is pending. Legal range 2..255.
- `clk`  input  1: single clock, rising edge.
- `rst_n`  input  1: reset, asynchronous and active-low.
- `req`  input  8: level requests. Bit i high means requester i wants the resource.
- `gnt`  output  8: registered one-hot grant, or all zero when idle.
- `gnt_idx`  output  3: binary index of the granted requester. Holds its last value when idle.
- `gnt_valid`  output  1: high when `gnt` is non-zero.
- `hold_cnt`  output  8: cycles the current grant has been held so far (debug/observability).

## Operation
- Two states: IDLE (no grant) and GRANT (one requester owns the resource).
- Priority pointer `ptr` (3 bits):
  - Search order is ptr, ptr+1, …, ptr+7, modulo 8 (wrap 7→0).
  - After every new grant to index k, `ptr` becomes k+1 mod 8.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise grant the first set bit in search order, go to GRANT, clear `hold_cnt` to 0.
- GRANT, owner k. Evaluated each cycle:
  - req[k] low: release. If any other request is set, grant the next one in search order in the same edge (no idle bubble). Otherwise go to IDLE with gnt=0.
  - req[k] high, no other request set: keep the grant. `hold_cnt` saturates at MAX_HOLD and does not force release.
  - req[k] high, other requests set, hold_cnt < MAX_HOLD-1: keep the grant, increment hold_cnt.
  - req[k] high, other requests set, hold_cnt == MAX_HOLD-1: forced rotation. Grant the next requester in search order, excluding k, and clear hold_cnt.
- Exactly one `gnt` bit is ever set. `gnt` always equals 1<<gnt_idx when gnt_valid is high.
- Arithmetic:
  - `ptr` and `gnt_idx` wrap modulo 8.
  - `hold_cnt` is 8 bits and never exceeds MAX_HOLD.

## Timing
- Reset values (asynchronous on rst_n low): gnt=0, gnt_idx=0, gnt_valid=0, hold_cnt=0, ptr=0, state=IDLE.
- After reset, requester 0 has highest priority.
- Reset mid-grant drops `gnt` immediately, without waiting for the clock. The first grant after release is decided at the first rising edge with rst_n high.
- Latency:
  - req rising at edge t (sampled) gives gnt at t+1, i.e. one cycle.
  - Owner dropping req sampled at edge t gives the new grant (or idle) visible after edge t.
- Simultaneous events:
  - Owner drops req in the same cycle a timeout would fire: treat as a normal release. The owner is not excluded unless it is still requesting.
  - New requests arriving during a grant wait for release or forced rotation; there is no preemption otherwise.
- All outputs are registered. There is no combinational path from req to gnt.

## Structure
- Shared package `arb_pkg`:
  - N, IDXW, MAX_HOLD defaults.
  - State encoding (IDLE=1'b0, GRANT=1'b1).
- Sub-module `rr_priority_pick`, combinational:
  - Inputs: 8-bit request vector, 3-bit start pointer, 8-bit exclude mask.
  - Outputs: found flag and 3-bit index.
  - Implement as a rotate → fixed-priority encode → un-rotate sequence.
- Top level holds:
  - State, ptr, hold_cnt and grant registers.
  - Index→one-hot conversion for `gnt`.

## Test plan
- Reset then req=8'b1000_0001: gnt=8'h01, idx=0 one cycle later. Drop req[0]: gnt=8'h80, idx=7 on the next edge. Drop req[7]: gnt=0, valid=0.
- req=8'hFF held for 40 cycles with MAX_HOLD=4: grants rotate 0,1,2,…,7,0 (wrap), each held exactly 4 cycles, hold_cnt cycles 0..3.
- Only req[5] high for 50 cycles: gnt=8'h20 throughout and hold_cnt saturates at MAX_HOLD. Then raise req[2]: rotation to idx 2 within MAX_HOLD−hold_cnt cycles.
- Owner 3 drops req in the exact timeout cycle while req[6] is set: idx 6 granted next edge, and ptr becomes 7.
- Assert rst_n low mid-grant of idx 4: gnt=0 asynchronously. On release with req=8'h30, the grant goes to idx 4 (ptr reset to 0, so search starts at 0).
- Random req for 10k cycles: checker confirms one-hot-or-zero gnt, gnt==1<<idx, and no starvation beyond 7·MAX_HOLD cycles.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter.
//   ARB_N        : default number of requesters (fixed at 8)
//   ARB_IDXW     : default width of the grant index
//   ARB_MAX_HOLD : default cap on consecutive cycles one grant is held
//                  while another request is pending
//   arb_state_e  : arbiter FSM encoding (IDLE = 0, GRANT = 1)
//   idx_to_onehot: index -> one-hot helper used to build gnt
package arb_pkg;

    localparam int ARB_N        = 8;
    localparam int ARB_IDXW     = 3;
    localparam int ARB_MAX_HOLD = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    function automatic logic [ARB_N-1:0] idx_to_onehot(input logic [ARB_IDXW-1:0] idx);
        logic [ARB_N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick.
// Finds the first request in the order start, start+1, ..., start+N-1
// (mod N), ignoring any bit set in excl.
//   req   : request vector
//   start : highest-priority position for this search
//   excl  : requests to ignore
//   found : at least one eligible request exists
//   idx   : index of the chosen request (don't care when found is low)
module rr_priority_pick
    import arb_pkg::*;
#(
    parameter int N    = ARB_N,
    parameter int IDXW = ARB_IDXW
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] start,
    input  logic [N-1:0]    excl,
    output logic            found,
    output logic [IDXW-1:0] idx
);

    logic [N-1:0]    masked;
    logic [2*N-1:0]  dbl;
    logic [N-1:0]    rot;
    logic [IDXW-1:0] off;

    // Rotate so that position 'start' lands on bit 0; doubling the vector
    // lets a plain part-select perform the wrap-around.
    assign masked = req & ~excl;
    assign dbl    = {masked, masked};
    assign rot    = dbl[start +: N];

    // Fixed-priority encode: lowest set bit of the rotated vector wins.
    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = IDXW'(i);
            end
        end
    end

    // Un-rotate. N is a power of two, so IDXW-bit addition wraps mod N.
    assign idx = start + off;

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a hold timer.
// A requester keeps the grant while it holds req high, but once others
// are waiting it is forced off after MAX_HOLD cycles.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   req       : level request vector
//   gnt       : registered one-hot grant (zero when idle)
//   gnt_idx   : binary index of the owner; holds its value when idle
//   gnt_valid : grant present; also mirrors the FSM state (1 = GRANT)
//   hold_cnt  : cycles the current grant has been held (saturates)
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int N        = ARB_N,
    parameter int IDXW     = ARB_IDXW,
    parameter int MAX_HOLD = ARB_MAX_HOLD
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic [7:0]      hold_cnt
);

    localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    arb_state_e      state, state_n;
    logic [IDXW-1:0] ptr, ptr_n;
    logic [IDXW-1:0] gnt_idx_n;
    logic [7:0]      hold_n;
    logic [N-1:0]    gnt_n;

    logic            pick_found;
    logic [IDXW-1:0] pick_idx;
    logic            owner_req;
    logic            others_req;
    logic            grant_now;

    // Excluding the current one-hot grant covers every case: when idle gnt
    // is zero, on release the owner's req bit is already low, and on a
    // forced rotation the still-requesting owner must be skipped.
    rr_priority_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_pick (
        .req   (req),
        .start (ptr),
        .excl  (gnt),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign owner_req  = req[gnt_idx];
    assign others_req = |(req & ~gnt);

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        gnt_idx_n = gnt_idx;
        hold_n    = hold_cnt;
        grant_now = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pick_found) grant_now = 1'b1;
            end
            ST_GRANT: begin
                if (!owner_req) begin
                    // Release; hand over in the same edge if anyone waits.
                    if (pick_found) begin
                        grant_now = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                        hold_n  = '0;
                    end
                end else if (!others_req) begin
                    // Sole requester: count up but never force release.
                    if (hold_cnt < HOLD_MAX) hold_n = hold_cnt + 8'd1;
                end else if (hold_cnt < HOLD_LAST) begin
                    hold_n = hold_cnt + 8'd1;
                end else begin
                    // Timeout (also reached when a saturated solo owner
                    // suddenly gets company).
                    grant_now = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (grant_now) begin
            state_n   = ST_GRANT;
            gnt_idx_n = pick_idx;
            ptr_n     = pick_idx + IDXW'(1);
            hold_n    = '0;
        end

        gnt_n = (state_n == ST_GRANT) ? idx_to_onehot(gnt_idx_n) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            gnt_idx   <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            gnt_idx   <= gnt_idx_n;
            hold_cnt  <= hold_n;
            gnt       <= gnt_n;
            gnt_valid <= (state_n == ST_GRANT);
        end
    end

endmodule
